neuron_layer_sequencer: RTL and testbench
=========================================

Name: neuron_layer_sequencer

Overview:
- Internal-side master feeding the neuron bus arbiter.
- On `start`, computes one fully connected layer. For each output neuron it reads input activations from neuron memory and reads weights from the weight memory.
- Multiply-accumulates, rescales and saturates the sum, then writes the result back to neuron memory.
- Drives all `*_int` arbiter inputs plus `select_external`. It holds the bus while busy and releases it to the external side otherwise.

Parameters:
- DATA_W, 8, neuron and weight width; signed two's complement.
- ADDR_W, 8, neuron memory address width.
- WEIGHT_AW, 16, weight memory address width.
- ACC_W, 24, signed accumulator width.
- FRAC_BITS, 4, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_base  in  ADDR_W  first input-neuron address; latched on start.
- in_count  in  ADDR_W  number of inputs; latched on start.
- out_base  in  ADDR_W  first output-neuron address; latched on start.
- out_count  in  ADDR_W  number of outputs; latched on start.
- neuron_read_address_int  out  ADDR_W  to arbiter.
- neuron_read_data  in  DATA_W  neuron memory read data; valid 1 cycle after the address.
- weight_address  out  WEIGHT_AW  weight memory address.
- weight_data  in  DATA_W  weight read data; valid 1 cycle after the address.
- neuron_write_address_int  out  ADDR_W  to arbiter.
- neuron_write_data_int  out  DATA_W  to arbiter.
- neuron_write_enable_int  out  1  to arbiter.
- select_external  out  1  to arbiter; 1 = external master owns the bus.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the layer is complete.

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - `rst_n` is asynchronous, active-low.
- Reset values:
  - All address and data outputs 0.
  - `neuron_write_enable_int` = 0, `busy` = 0, `done` = 0.
  - `select_external` = 1.
  - FSM in IDLE; accumulator 0.
- FSM states: IDLE, ISSUE, MAC, WRITE, NEXT, DONE.
  - IDLE: on `start`, latch bases and counts, clear i, j, weight pointer and accumulator, assert `busy`, deassert `select_external`.
    - If `out_count` == 0, go to DONE; otherwise go to ISSUE.
  - ISSUE: drive `neuron_read_address_int` = in_base+i (mod 2^ADDR_W) and `weight_address` = weight pointer.
    - If `in_count` == 0, go to WRITE; otherwise go to MAC.
  - MAC: acc += sext(neuron_read_data) * sext(weight_data); increment weight pointer and i.
    - If i == in_count-1, go to WRITE; else go to ISSUE.
    - Each input costs 2 cycles.
  - WRITE: assert `neuron_write_enable_int` for exactly one cycle.
    - `neuron_write_address_int` = out_base+j (mod 2^ADDR_W).
    - `neuron_write_data_int` = sat(acc >>> FRAC_BITS) to [-128, 127].
    - Go to NEXT.
  - NEXT: clear acc and i; increment j.
    - If j was out_count-1, go to DONE; else go to ISSUE.
  - DONE: pulse `done`, drop `busy`, set `select_external` = 1, return to IDLE.
- Weight addressing:
  - Row-major, weight[j][i] at j*in_count+i.
  - Produced by the incrementing pointer only; no multiplier.
- Saturation and overflow:
  - Saturation uses the full-width shifted value.
  - The accumulator does not saturate internally; overflow beyond ACC_W is out of scope.
- Boundary conditions:
  - `start` while busy is ignored.
  - `start` in DONE is ignored; it is re-accepted next cycle in IDLE.
  - Address computation wraps modulo 2^ADDR_W; no error is flagged.
- Bus hygiene:
  - `neuron_write_enable_int` is never high while `select_external` = 1.
  - Write address and data are held stable in WRITE only; both are 0 otherwise.
- Reset mid-operation: all outputs immediately take their reset values. No write occurs and no `done` pulses.

Optional Feature:
- Macro `NEURON_RELU_EN`.
- Defined: write data = max(0, sat(acc >>> FRAC_BITS)); negative results are written as 0.
- Undefined: the signed saturated value is written unchanged.

Decomposition:
- Shared package `neuron_pkg`: DATA_W/ADDR_W defaults, the FSM state enum, and a `sat_to_data` function (shift plus clamp).
- One natural sub-module: `neuron_mac_unit`, holding the accumulator register, signed multiply-add, clear, and saturating/ReLU output.

Test Plan:
- Reset check: hold rst_n=0 → select_external=1, busy=0, write_enable=0. Assert rst_n mid-MAC → the same values appear immediately, with no write and no done.
- Basic layer: in_base=0x00, in_count=2, out_base=0x10, out_count=1, activations {16,32}, weights {16,16}, FRAC_BITS=4. Expect one write to 0x10 of value 48, then a done pulse. Latency start→done = 1+2*2+1+1+1 cycles.
- Saturation: activations {127,127}, weights {127,127} → write 127. With weight -127: write -128 without the macro, 0 with NEURON_RELU_EN.
- Multi-output and weight order: in_count=3, out_count=2. weight_address sequence is 0..5; writes go to out_base and out_base+1 in order.
- Degenerate counts:
  - out_count=0 → done 2 cycles after start, with no reads and no writes.
  - in_count=0, out_count=2 → two writes of 0.
- Wrap and busy: in_base=0xFF, in_count=2 → read addresses 0xFF then 0x00. A second `start` during busy → no restart and exactly one done.

Source files
------------

// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron layer sequencer:
//   - default widths for data, neuron address, weight address, accumulator
//   - FSM state enum used by the sequencer
//   - sat_to_data: arithmetic shift plus clamp to a signed data width
// Optional feature macro used elsewhere in this slice: NEURON_RELU_EN.
// No ports (package).
// -----------------------------------------------------------------------------
package neuron_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned WEIGHT_AW_DEF = 16;
  localparam int unsigned ACC_W_DEF     = 24;
  localparam int unsigned FRAC_BITS_DEF = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StMac,
    StWrite,
    StNext,
    StDone
  } state_e;

  // Works on a 64-bit sign-extended accumulator so any ACC_W up to 64 fits;
  // the caller keeps the low data_w bits of the clamped result.
  function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] acc,
                                                     input int unsigned frac_bits,
                                                     input int unsigned data_w);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = acc >>> frac_bits;
    max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) begin
      sat_to_data = max_v;
    end else if (shifted < min_v) begin
      sat_to_data = min_v;
    end else begin
      sat_to_data = shifted;
    end
  endfunction

endpackage

// File: rtl/neuron_mac_unit.sv
// -----------------------------------------------------------------------------
// neuron_mac_unit
// Signed multiply-accumulate with synchronous clear and a rescaled, saturated
// output. With NEURON_RELU_EN defined, negative results are forced to 0.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        clear accumulator (priority over i_en)
//   i_en           accumulate i_act * i_wgt this cycle
//   i_act, i_wgt   signed activation and weight
//   o_result       sat(acc >>> FRAC_BITS), optionally ReLU'd
// -----------------------------------------------------------------------------
module neuron_mac_unit
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_act,
  input  logic [DATA_W-1:0] i_wgt,
  output logic [DATA_W-1:0] o_result
);

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [63:0]         w_sat;
  logic                       w_sat_unused;

  assign w_prod = $signed(i_act) * $signed(i_wgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign w_sat = sat_to_data(64'(r_acc), FRAC_BITS, DATA_W);

  // After the clamp the upper bits only replicate the sign.
  assign w_sat_unused = ^w_sat[63:DATA_W];

  always_comb begin
`ifdef NEURON_RELU_EN
    o_result = w_sat[63] ? '0 : w_sat[DATA_W-1:0];
`else
    o_result = w_sat[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_layer_sequencer
// Internal-side bus master that computes one fully connected layer per start:
// for each output neuron it reads in_count activations and weights, MACs them,
// rescales/saturates and writes the result back through the neuron arbiter.
// Optional feature: define NEURON_RELU_EN to write max(0, result).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start                            one-cycle request, sampled in IDLE only
//   in_base/in_count                 input neuron window (latched on start)
//   out_base/out_count               output neuron window (latched on start)
//   neuron_read_address_int          read address to arbiter
//   neuron_read_data                 read data, valid 1 cycle after address
//   weight_address/weight_data       weight memory port, 1-cycle latency
//   neuron_write_address_int/_data_int/_enable_int   write port to arbiter
//   select_external                  1 = external master owns the bus
//   busy, done                       status; done is a one-cycle pulse
// -----------------------------------------------------------------------------
module neuron_layer_sequencer
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned WEIGHT_AW = WEIGHT_AW_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    in_base,
  input  logic [ADDR_W-1:0]    in_count,
  input  logic [ADDR_W-1:0]    out_base,
  input  logic [ADDR_W-1:0]    out_count,
  output logic [ADDR_W-1:0]    neuron_read_address_int,
  input  logic [DATA_W-1:0]    neuron_read_data,
  output logic [WEIGHT_AW-1:0] weight_address,
  input  logic [DATA_W-1:0]    weight_data,
  output logic [ADDR_W-1:0]    neuron_write_address_int,
  output logic [DATA_W-1:0]    neuron_write_data_int,
  output logic                 neuron_write_enable_int,
  output logic                 select_external,
  output logic                 busy,
  output logic                 done
);

  state_e                r_state;
  logic [ADDR_W-1:0]     r_in_base;
  logic [ADDR_W-1:0]     r_in_count;
  logic [ADDR_W-1:0]     r_out_base;
  logic [ADDR_W-1:0]     r_out_count;
  logic [ADDR_W-1:0]     r_i;
  logic [ADDR_W-1:0]     r_j;
  logic [WEIGHT_AW-1:0]  r_wptr;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [WEIGHT_AW-1:0]  r_wt_addr;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sel_ext;

  logic                  w_acc_clear;
  logic                  w_acc_en;
  logic [DATA_W-1:0]     w_result;

  assign w_acc_clear = ((r_state == StIdle) && start) || (r_state == StNext);
  assign w_acc_en    = (r_state == StMac);

  // Addresses are loaded on entry to ISSUE/WRITE so they are valid for the
  // whole state and zero elsewhere. Weight order comes from the running
  // pointer alone: row j starts where row j-1 ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_in_base   <= '0;
      r_in_count  <= '0;
      r_out_base  <= '0;
      r_out_count <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_wptr      <= '0;
      r_rd_addr   <= '0;
      r_wt_addr   <= '0;
      r_wr_addr   <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sel_ext   <= 1'b1;
    end else begin
      r_rd_addr <= '0;
      r_wt_addr <= '0;
      r_wr_addr <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_in_base   <= in_base;
            r_in_count  <= in_count;
            r_out_base  <= out_base;
            r_out_count <= out_count;
            r_i         <= '0;
            r_j         <= '0;
            r_wptr      <= '0;
            r_busy      <= 1'b1;
            r_sel_ext   <= 1'b0;
            if (out_count == '0) begin
              r_state <= StDone;
            end else begin
              r_state   <= StIssue;
              r_rd_addr <= in_base;
            end
          end
        end
        StIssue: begin
          if (r_in_count == '0) begin
            r_state   <= StWrite;
            r_we      <= 1'b1;
            r_wr_addr <= r_out_base + r_j;
          end else begin
            r_state <= StMac;
          end
        end
        StMac: begin
          r_wptr <= r_wptr + WEIGHT_AW'(1);
          r_i    <= r_i + ADDR_W'(1);
          if (r_i == r_in_count - ADDR_W'(1)) begin
            r_state   <= StWrite;
            r_we      <= 1'b1;
            r_wr_addr <= r_out_base + r_j;
          end else begin
            r_state   <= StIssue;
            r_rd_addr <= r_in_base + r_i + ADDR_W'(1);
            r_wt_addr <= r_wptr + WEIGHT_AW'(1);
          end
        end
        StWrite: begin
          r_state <= StNext;
        end
        StNext: begin
          r_i <= '0;
          r_j <= r_j + ADDR_W'(1);
          if (r_j == r_out_count - ADDR_W'(1)) begin
            r_state <= StDone;
          end else begin
            r_state   <= StIssue;
            r_rd_addr <= r_in_base;
            r_wt_addr <= r_wptr;
          end
        end
        StDone: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_sel_ext <= 1'b1;
          r_state   <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  neuron_mac_unit #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_acc_clear),
    .i_en     (w_acc_en),
    .i_act    (neuron_read_data),
    .i_wgt    (weight_data),
    .o_result (w_result)
  );

  assign neuron_read_address_int  = r_rd_addr;
  assign weight_address           = r_wt_addr;
  assign neuron_write_address_int = r_wr_addr;
  // Accumulator is stable during WRITE, so the gated combinational result is clean.
  assign neuron_write_data_int    = r_we ? w_result : '0;
  assign neuron_write_enable_int  = r_we;
  assign select_external          = r_sel_ext;
  assign busy                     = r_busy;
  assign done                     = r_done;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer_sequencer
// Self-checking bench for neuron_layer_sequencer. Expected writes are computed
// from the bench's own memory images and queued before start; a monitor pops
// and compares them as the DUT writes. Honors NEURON_RELU_EN when defined.
// -----------------------------------------------------------------------------
module tb_neuron_layer_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_base;
  logic [7:0]  in_count;
  logic [7:0]  out_base;
  logic [7:0]  out_count;
  logic [7:0]  neuron_read_address_int;
  logic [7:0]  neuron_read_data;
  logic [15:0] weight_address;
  logic [7:0]  weight_data;
  logic [7:0]  neuron_write_address_int;
  logic [7:0]  neuron_write_data_int;
  logic        neuron_write_enable_int;
  logic        select_external;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t               exp_q[$];
  int                n_cmp;
  int                n_err;
  logic signed [7:0] nmem [256];
  logic signed [7:0] wmem [64];

  neuron_layer_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .in_base                  (in_base),
    .in_count                 (in_count),
    .out_base                 (out_base),
    .out_count                (out_count),
    .neuron_read_address_int  (neuron_read_address_int),
    .neuron_read_data         (neuron_read_data),
    .weight_address           (weight_address),
    .weight_data              (weight_data),
    .neuron_write_address_int (neuron_write_address_int),
    .neuron_write_data_int    (neuron_write_data_int),
    .neuron_write_enable_int  (neuron_write_enable_int),
    .select_external          (select_external),
    .busy                     (busy),
    .done                     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    neuron_read_data <= nmem[neuron_read_address_int];
    weight_data      <= wmem[weight_address[5:0]];
  end

  function automatic logic [7:0] exp_out(input int acc);
    int s;
    s = acc >>> 4;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s);
  endfunction

  // Write scoreboard and bus hygiene monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (neuron_write_enable_int === 1'b1) begin
        n_cmp++;
        if (select_external !== 1'b0) begin
          n_err++;
          $display("FAIL bus_hygiene: write_enable=1 with select_external=%b, required 0",
                   select_external);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr=%02h data=%02h, required no write",
                   neuron_write_address_int, neuron_write_data_int);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({neuron_write_address_int, neuron_write_data_int} !== e) begin
            n_err++;
            $display("FAIL write_check: got addr=%02h data=%02h, required addr=%02h data=%02h",
                     neuron_write_address_int, neuron_write_data_int, e.addr, e.data);
          end
        end
      end else begin
        n_cmp++;
        if (neuron_write_address_int !== 8'h00 || neuron_write_data_int !== 8'h00) begin
          n_err++;
          $display("FAIL write_idle_zero: addr=%02h data=%02h, required 00/00",
                   neuron_write_address_int, neuron_write_data_int);
        end
      end
    end
  end

  // Runs one layer, checking the cycle-accurate schedule: ISSUE addresses,
  // write-enable placement, busy/select_external and start-to-done latency.
  task automatic run_layer(input int ib, input int ic, input int ob, input int oc,
                           input int restart_at, input bit no_gap, input string name);
    int p;
    int lat;
    int cyc;
    int off;
    int j;
    int r;
    int i;
    bit exp_we;
    for (int jj = 0; jj < oc; jj++) begin
      int acc;
      acc = 0;
      for (int ii = 0; ii < ic; ii++) begin
        int a;
        int w;
        a = nmem[(ib + ii) % 256];
        w = wmem[(jj * ic + ii) % 64];
        acc += a * w;
      end
      exp_q.push_back('{addr: 8'((ob + jj) % 256), data: exp_out(acc)});
    end
    p   = (ic == 0) ? 3 : 2 * ic + 2;
    lat = oc * p + 2;
    if (!no_gap) @(negedge clk);
    in_base   = 8'(ib);
    in_count  = 8'(ic);
    out_base  = 8'(ob);
    out_count = 8'(oc);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (1) begin
      if (cyc < lat) begin
        n_cmp++;
        if (busy !== 1'b1 || select_external !== 1'b0 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s_status c%0d: busy=%b sel_ext=%b done=%b, required 1/0/0",
                   name, cyc, busy, select_external, done);
        end
        off    = cyc - 1;
        j      = off / p;
        r      = off % p;
        exp_we = (j < oc) && (r == p - 2);
        n_cmp++;
        if (neuron_write_enable_int !== exp_we) begin
          n_err++;
          $display("FAIL %s_we_timing c%0d: got %b, required %b",
                   name, cyc, neuron_write_enable_int, exp_we);
        end
        if (j < oc && r < ((ic == 0) ? 1 : 2 * ic) && (r % 2) == 0) begin
          i = r / 2;
          n_cmp++;
          if (neuron_read_address_int !== 8'((ib + i) % 256)) begin
            n_err++;
            $display("FAIL %s_read_addr c%0d: got %02h, required %02h",
                     name, cyc, neuron_read_address_int, 8'((ib + i) % 256));
          end
          if (ic != 0) begin
            n_cmp++;
            if (weight_address !== 16'(j * ic + i)) begin
              n_err++;
              $display("FAIL %s_weight_addr c%0d: got %0d, required %0d",
                       name, cyc, weight_address, j * ic + i);
            end
          end
        end
      end
      if (done === 1'b1 || cyc >= lat + 20) break;
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || cyc != lat) begin
      n_err++;
      $display("FAIL %s_latency: done=%b after %0d cycles, required done=1 after %0d",
               name, done, cyc, lat);
    end
    n_cmp++;
    if (busy !== 1'b0 || select_external !== 1'b1) begin
      n_err++;
      $display("FAIL %s_release: busy=%b sel_ext=%b, required 0/1", name, busy, select_external);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_writes_missing: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (select_external !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        neuron_write_enable_int !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: sel=%b busy=%b done=%b we=%b, required 1/0/0/0",
               select_external, busy, done, neuron_write_enable_int);
    end
    n_cmp++;
    if (neuron_read_address_int !== 8'h00 || weight_address !== 16'h0000 ||
        neuron_write_address_int !== 8'h00 || neuron_write_data_int !== 8'h00) begin
      n_err++;
      $display("FAIL reset_addr: rd=%02h wt=%04h wa=%02h wd=%02h, required all 0",
               neuron_read_address_int, weight_address, neuron_write_address_int,
               neuron_write_data_int);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || select_external !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: busy=%b sel=%b, required 0/1", busy, select_external);
    end
  endtask

  task automatic test_basic();
    nmem[8'h00] = 8'sd16;
    nmem[8'h01] = 8'sd32;
    wmem[0]     = 8'sd16;
    wmem[1]     = 8'sd16;
    run_layer(8'h00, 2, 8'h10, 1, -1, 1'b0, "basic");
  endtask

  task automatic test_saturation();
    nmem[8'h80] = 8'sd127;
    nmem[8'h81] = 8'sd127;
    wmem[0]     = 8'sd127;
    wmem[1]     = 8'sd127;
    run_layer(8'h80, 2, 8'h11, 1, -1, 1'b0, "sat_pos");
    wmem[0] = -8'sd127;
    wmem[1] = -8'sd127;
    run_layer(8'h80, 2, 8'h12, 1, -1, 1'b0, "sat_neg");
  endtask

  task automatic test_multi_output();
    nmem[8'h20] = 8'sd40;
    nmem[8'h21] = -8'sd24;
    nmem[8'h22] = 8'sd56;
    wmem[0] = 8'sd8;
    wmem[1] = 8'sd16;
    wmem[2] = 8'sd24;
    wmem[3] = -8'sd32;
    wmem[4] = 8'sd48;
    wmem[5] = 8'sd4;
    run_layer(8'h20, 3, 8'h40, 2, -1, 1'b0, "multi");
  endtask

  task automatic test_degenerate();
    run_layer(8'h30, 2, 8'h50, 0, -1, 1'b0, "out_zero");
    run_layer(8'h30, 0, 8'h60, 2, -1, 1'b0, "in_zero");
  endtask

  task automatic test_wrap_busy();
    nmem[8'hFF] = 8'sd10;
    nmem[8'h00] = -8'sd20;
    wmem[0] = 8'sd3;
    wmem[1] = 8'sd5;
    wmem[2] = -8'sd2;
    wmem[3] = 8'sd7;
    // Second start at cycle 3 lands mid-layer and must be ignored.
    run_layer(8'hFF, 2, 8'hFF, 2, 3, 1'b0, "wrap_busy");
  endtask

  task automatic test_back_to_back();
    nmem[8'h00] = 8'sd16;
    nmem[8'h01] = 8'sd32;
    wmem[0]     = 8'sd16;
    wmem[1]     = 8'sd16;
    // Start raised during the DONE cycle (cycle 7) must be dropped.
    run_layer(8'h00, 2, 8'h70, 1, 7, 1'b0, "start_in_done");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_done c%0d: busy=%b done=%b, required 0/0", k, busy, done);
      end
    end
    run_layer(8'h00, 2, 8'h71, 1, -1, 1'b0, "b2b_first");
    // Start in the cycle done is visible (FSM back in IDLE) is accepted.
    run_layer(8'h00, 2, 8'h72, 1, -1, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk);
    in_base   = 8'h00;
    in_count  = 8'd2;
    out_base  = 8'h10;
    out_count = 8'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (select_external !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        neuron_write_enable_int !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: sel=%b busy=%b done=%b we=%b, required 1/0/0/0",
               select_external, busy, done, neuron_write_enable_int);
    end
    n_cmp++;
    if (neuron_read_address_int !== 8'h00 || weight_address !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid_addr: rd=%02h wt=%04h, required 00/0000",
               neuron_read_address_int, weight_address);
    end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: %0d busy/done cycles after reset, required 0", done_seen);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_base   = 8'h00;
    in_count  = 8'h00;
    out_base  = 8'h00;
    out_count = 8'h00;
    for (int k = 0; k < 256; k++) nmem[k] = 8'sd0;
    for (int k = 0; k < 64; k++) wmem[k] = 8'sd0;

    test_reset();
    test_basic();
    test_saturation();
    test_multi_output();
    test_degenerate();
    test_wrap_busy();
    test_reset_mid();
    test_back_to_back();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
